// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32/RV64 integer-subset core: ld/sd, add/sub/and/or, addi, beq.
// One instruction at a time walks a control FSM; all memory traffic goes through
// a single req/ready port so the attached memory may insert any number of waits.
module multicycle_cpu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     retired,
  output logic            halted
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StBranch,
    StHalt
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  // Load/store width follows XLEN: doubleword on RV64, word on RV32.
  localparam logic [2:0] LsFunct3 = (XLEN == 64) ? 3'b011 : 3'b010;

  // Architectural and microarchitectural state
  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   old_pc_q, old_pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   mdr_q, mdr_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   alu_out_q, alu_out_d;
  logic [31:0]       retired_q, retired_d;
  logic [XLEN-1:0]   rf_q [32];
  logic [XLEN-1:0]   rf_d [32];

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // Sign-extended immediates
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;

  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  // Legal-encoding decode; anything not matched exactly lands in HALT
  logic is_ld;
  logic is_sd;
  logic is_rtype;
  logic is_addi;
  logic is_beq;

  // Decode the held instruction word
  always_comb begin
    is_ld    = (opcode == OpLoad)  && (funct3 == LsFunct3);
    is_sd    = (opcode == OpStore) && (funct3 == LsFunct3);
    is_addi  = (opcode == OpImm)   && (funct3 == 3'b000);
    is_beq   = (opcode == OpBranch) && (funct3 == 3'b000);
    is_rtype = 1'b0;
    if (opcode == OpReg) begin
      if (funct7 == 7'b0000000) begin
        is_rtype = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110);
      end else if (funct7 == 7'b0100000) begin
        is_rtype = (funct3 == 3'b000);
      end
    end
  end

  // Register file read; x0 is never written so it always reads zero
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  // ALU for EXEC: add by default, R-type selects sub/and/or
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;

  // Compute the EXEC-stage ALU result from A and B or the I-immediate
  always_comb begin
    alu_b      = (opcode == OpImm) ? imm_i : b_q;
    alu_result = a_q + alu_b;
    if (opcode == OpReg) begin
      if (funct7[5]) begin
        alu_result = a_q - b_q;
      end else if (funct3 == 3'b111) begin
        alu_result = a_q & b_q;
      end else if (funct3 == 3'b110) begin
        alu_result = a_q | b_q;
      end
    end
  end

  // Register write-back request from MEMWB / ALUWB
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  // Next-state logic for the control FSM and all datapath registers
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    old_pc_d  = old_pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    retired_d = retired_q;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    rf_d      = rf_q;

    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_d     = mem_rdata[31:0];
          old_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = StDecode;
        end
      end
      StDecode: begin
        a_d       = rs1_val;
        b_d       = rs2_val;
        // Branch target computed speculatively while the ALU is otherwise idle
        alu_out_d = old_pc_q + imm_b;
        if (is_ld || is_sd) begin
          state_d = StMemAdr;
        end else if (is_rtype || is_addi) begin
          state_d = StExec;
        end else if (is_beq) begin
          state_d = StBranch;
        end else begin
          state_d = StHalt;
        end
      end
      StMemAdr: begin
        alu_out_d = a_q + (is_sd ? imm_s : imm_i);
        state_d   = is_sd ? StMemWr : StMemRd;
      end
      StMemRd: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        rf_we     = 1'b1;
        rf_wdata  = mdr_q;
        retired_d = retired_q + 32'd1;
        state_d   = StFetch;
      end
      StMemWr: begin
        if (mem_ready) begin
          retired_d = retired_q + 32'd1;
          state_d   = StFetch;
        end
      end
      StExec: begin
        alu_out_d = alu_result;
        state_d   = StAluWb;
      end
      StAluWb: begin
        rf_we     = 1'b1;
        rf_wdata  = alu_out_q;
        retired_d = retired_q + 32'd1;
        state_d   = StFetch;
      end
      StBranch: begin
        if (a_q == b_q) begin
          pc_d = alu_out_q;
        end
        retired_d = retired_q + 32'd1;
        state_d   = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase

    if (rf_we && (rd != 5'd0)) begin
      rf_d[rd] = rf_wdata;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      old_pc_q  <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      retired_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      old_pc_q  <= old_pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      retired_q <= retired_d;
      rf_q      <= rf_d;
    end
  end

  // Moore memory-port outputs; reset gates the request off combinationally
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = alu_out_q;
    mem_wdata = b_q;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
        end
        StMemRd: begin
          mem_req = 1'b1;
        end
        StMemWr: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;
  assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu (XLEN=64, RESET_PC=0x100). The main process
// loads directed programs and queues every memory transaction the core should
// make; a monitor pops and checks each transaction as the memory accepts it.
module tb_multicycle_cpu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic [63:0] pc;
  logic [31:0] retired;
  logic        halted;

  multicycle_cpu #(
    .XLEN    (64),
    .RESET_PC(64'h100)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .pc       (pc),
    .retired  (retired),
    .halted   (halted)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Byte-addressed little-endian memory
  logic [7:0] mem [0:1023];

  function automatic logic [63:0] rd64(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[10'(a + 64'(i))];
    return r;
  endfunction

  task automatic wr64(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) mem[10'(a + 64'(i))] = d[8*i +: 8];
  endtask

  task automatic put_word(input logic [63:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[10'(a + 64'(i))] = w[8*i +: 8];
  endtask

  // Data and the 0x110..0x12F fetch window see two wait states; the rest are zero-wait
  function automatic int wait_for(input logic [63:0] a);
    return (a < 64'h100 || (a >= 64'h110 && a < 64'h130)) ? 2 : 0;
  endfunction

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] ld(input logic [4:0] rd, input logic [11:0] imm);
    return enc_i(imm, 5'd0, 3'b011, rd, 7'b0000011);
  endfunction

  // Scoreboard of expected accepted transactions
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    int          gap;   // cycles since previous accept, -1 = unchecked
    int          hold;  // cycles the request is presented
  } txn_t;

  txn_t exp_q[$];

  task automatic expect_txn(input logic we, input logic [63:0] addr, input logic [63:0] data,
                            input int gap, input int hold);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.gap = gap; t.hold = hold;
    exp_q.push_back(t);
  endtask

  task automatic exp_f(input logic [63:0] addr, input int gap);
    expect_txn(1'b0, addr, 64'd0, gap, wait_for(addr) + 1);
  endtask

  // Memory model: decides ready for the coming posedge and performs the access
  int wcnt = 0;
  always @(negedge clock) begin
    if (reset || !mem_req) begin
      wcnt      = 0;
      mem_ready = 1'b0;
    end else if (wcnt >= wait_for(mem_addr)) begin
      mem_ready = 1'b1;
      mem_rdata = rd64(mem_addr);
      if (mem_we) wr64(mem_addr, mem_wdata);
      wcnt = 0;
    end else begin
      mem_ready = 1'b0;
      wcnt++;
    end
  end

  // Monitor: tracks request stability and pops the scoreboard on each accept
  int          cyc = 0;
  int          last_acc = 0;
  int          hold = 0;
  logic        h_we;
  logic [63:0] h_addr;
  logic [63:0] h_wdata;
  logic        stable;
  always @(negedge clock) begin
    txn_t e;
    #1;
    cyc++;
    if (reset || !mem_req) begin
      hold = 0;
    end else begin
      if (hold == 0) begin
        h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata; stable = 1'b1;
      end else if (mem_we !== h_we || mem_addr !== h_addr || (mem_we && mem_wdata !== h_wdata)) begin
        stable = 1'b0;
      end
      hold++;
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_txn: got we=%0b addr=0x%0h wdata=0x%0h expected none",
                   mem_we, mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("txn_we@%0h", e.addr), 64'(mem_we), 64'(e.we));
          check("txn_addr", mem_addr, e.addr);
          if (e.we) check($sformatf("store_data@%0h", e.addr), mem_wdata, e.data);
          if (e.gap >= 0) check($sformatf("gap@%0h", e.addr), 64'(cyc - last_acc), 64'(e.gap));
          check($sformatf("hold@%0h", e.addr), 64'(hold), 64'(e.hold));
          check($sformatf("stable@%0h", e.addr), 64'(stable), 64'd1);
        end
        last_acc = cyc;
        hold     = 0;
      end
    end
  end

  task automatic wait_halt(input int budget, input string name);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_halted"}, 64'(halted), 64'd1);
  endtask

  task automatic check_quiet(input string name);
    int reqs = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (mem_req || !halted) reqs++;
    end
    check(name, 64'(reqs), 64'd0);
  endtask

  initial begin
    int found;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    // Phase 1: ALU, load/store with waits, branches, x0, illegal opcode
    put_word(64'h100, addi(5'd1, 5'd0, 12'd5));
    put_word(64'h104, addi(5'd2, 5'd0, 12'hFFD));
    put_word(64'h108, enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));  // add x3,x1,x2
    put_word(64'h10C, enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd4));  // sub x4,x2,x1
    put_word(64'h110, enc_s(12'd8, 5'd3, 5'd0));                     // sd x3,8(x0)
    put_word(64'h114, ld(5'd5, 12'd8));                              // ld x5,8(x0)
    put_word(64'h118, enc_s(12'd24, 5'd5, 5'd0));                    // sd x5,24(x0)
    put_word(64'h11C, enc_s(12'd16, 5'd4, 5'd0));                    // sd x4,16(x0)
    put_word(64'h120, enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd6));  // and x6,x1,x2
    put_word(64'h124, enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd7));  // or x7,x1,x2
    put_word(64'h128, enc_s(12'd32, 5'd6, 5'd0));
    put_word(64'h12C, enc_s(12'd40, 5'd7, 5'd0));
    put_word(64'h130, enc_b(13'd16, 5'd2, 5'd1));                    // not taken
    put_word(64'h134, enc_b(13'd12, 5'd1, 5'd1));                    // -> 0x140
    put_word(64'h138, addi(5'd0, 5'd0, 12'd7));
    put_word(64'h13C, enc_b(13'd12, 5'd0, 5'd0));                    // -> 0x148
    put_word(64'h140, enc_b(13'h1FF8, 5'd1, 5'd1));                  // -8 -> 0x138
    put_word(64'h144, enc_s(12'd48, 5'd1, 5'd0));                    // skipped
    put_word(64'h148, enc_s(12'd48, 5'd0, 5'd0));                    // sd x0,48(x0)
    put_word(64'h14C, 32'hFFFF_FFFF);

    exp_f(64'h100, -1);
    exp_f(64'h104, 4);
    exp_f(64'h108, 4);
    exp_f(64'h10C, 4);
    exp_f(64'h110, 6);
    expect_txn(1'b1, 64'd8, 64'd2, 5, 3);
    exp_f(64'h114, 3);
    expect_txn(1'b0, 64'd8, 64'd0, 5, 3);
    exp_f(64'h118, 4);
    expect_txn(1'b1, 64'd24, 64'd2, 5, 3);
    exp_f(64'h11C, 3);
    expect_txn(1'b1, 64'd16, 64'hFFFF_FFFF_FFFF_FFF8, 5, 3);
    exp_f(64'h120, 3);
    exp_f(64'h124, 6);
    exp_f(64'h128, 6);
    expect_txn(1'b1, 64'd32, 64'd5, 5, 3);
    exp_f(64'h12C, 3);
    expect_txn(1'b1, 64'd40, 64'hFFFF_FFFF_FFFF_FFFD, 5, 3);
    exp_f(64'h130, 1);
    exp_f(64'h134, 3);
    exp_f(64'h140, 3);
    exp_f(64'h138, 3);
    exp_f(64'h13C, 4);
    exp_f(64'h148, 3);
    expect_txn(1'b1, 64'd48, 64'd0, 5, 3);
    exp_f(64'h14C, 1);

    repeat (3) @(posedge clock);
    #1;
    check("reset_pc", pc, 64'h100);
    check("reset_retired", 64'(retired), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_mem_we", 64'(mem_we), 64'd0);
    check("reset_halted", 64'(halted), 64'd0);
    #1 reset = 1'b0;
    #1;
    check("first_req", 64'(mem_req), 64'd1);
    check("first_addr", mem_addr, 64'h100);

    repeat (15) @(posedge clock);
    #1 check("retired_at_15", 64'(retired), 64'd3);
    @(posedge clock);
    #1 check("retired_at_16", 64'(retired), 64'd4);

    wait_halt(2000, "p1");
    check("p1_retired", 64'(retired), 64'd18);
    check("p1_pc", pc, 64'h150);
    check_quiet("p1_quiet_after_halt");
    check("p1_queue_drained", 64'(exp_q.size()), 64'd0);

    // Phase 2: reset while a load waits; the load must leave no trace
    reset = 1'b1;
    put_word(64'h100, enc_s(12'd56, 5'd5, 5'd0));  // sd x5,56(x0)
    put_word(64'h104, ld(5'd5, 12'd16));           // ld x5,16(x0)
    put_word(64'h108, enc_s(12'd64, 5'd5, 5'd0));  // sd x5,64(x0)
    put_word(64'h10C, 32'h0000_0000);
    exp_f(64'h100, -1);
    expect_txn(1'b1, 64'd56, 64'd0, 5, 3);
    exp_f(64'h104, 1);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(posedge clock); #1;
      if (mem_req && !mem_we && mem_addr == 64'd16) found = 1;
    end
    check("p2_load_seen", 64'(found), 64'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("p2_reset_mem_req", 64'(mem_req), 64'd0);
    check("p2_reset_pc", pc, 64'h100);
    check("p2_reset_retired", 64'(retired), 64'd0);
    check("p2_run1_drained", 64'(exp_q.size()), 64'd0);

    exp_f(64'h100, -1);
    expect_txn(1'b1, 64'd56, 64'd0, 5, 3);
    exp_f(64'h104, 1);
    expect_txn(1'b0, 64'd16, 64'd0, 5, 3);
    exp_f(64'h108, 2);
    expect_txn(1'b1, 64'd64, 64'hFFFF_FFFF_FFFF_FFF8, 5, 3);
    exp_f(64'h10C, 1);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    wait_halt(500, "p2");
    check("p2_retired", 64'(retired), 64'd3);
    check("p2_pc", pc, 64'h110);
    check_quiet("p2_quiet_after_halt");
    check("p2_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

- Parametrised multi-cycle RISC-V core: datapath plus an integrated control FSM.
- Executes an integer subset: ld/sd (lw/sw at XLEN=32), add/sub/and/or, addi, beq.
- Talks to external unified memory over a single req/ready handshake, so variable-latency memories are supported.
- Serves as the top-level CPU for the multicycle test system and drives its memory model directly.

## Interface
- XLEN, 64, datapath and register width; legal values 32 or 64.
- RESET_PC, 0, byte address loaded into PC on reset.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_req  out  1  memory access request; held until accepted.
- mem_we  out  1  1 = store, 0 = read; valid while mem_req=1.
- mem_addr  out  XLEN  byte address; valid while mem_req=1.
- mem_wdata  out  XLEN  store data (register rs2); valid while mem_req=1 and mem_we=1.
- mem_ready  in  1  memory accepts or completes the access in the current cycle.
- mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1; instruction is bits [31:0].
- pc  out  XLEN  current PC.
- retired  out  32  retired-instruction counter, wraps 2^32-1 -> 0.
- halted  out  1  core is in HALT.

## Operation
- State: PC, OldPC, IR (32), MDR, A, B, ALUOut (XLEN), register file 32 x XLEN.
  - x0 reads 0; writes to x0 are discarded.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, HALT.
- FETCH
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ready: IR<=mem_rdata[31:0], OldPC<=PC, PC<=PC+4, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - A<=rs1, B<=rs2, ALUOut<=OldPC+B-immediate.
  - Dispatch: ld/sd -> MEMADR; R-type or addi -> EXEC; beq -> BRANCH; else -> HALT.
- Legal encodings (all others, including wrong funct3/funct7, go to HALT):
  - ld: opcode 0000011, funct3 011 (010 when XLEN=32).
  - sd: opcode 0100011, funct3 011 (010 when XLEN=32).
  - R-type: opcode 0110011 with funct7/funct3 = 0000000/000 add, 0100000/000 sub, 0000000/111 and, 0000000/110 or.
  - addi: opcode 0010011, funct3 000.
  - beq: opcode 1100011, funct3 000.
- MEMADR: ALUOut<=A+imm, where imm is the I-immediate for ld and the S-immediate for sd, sign-extended to XLEN. Next: MEMRD for ld, MEMWR for sd.
- MEMRD: request a read at ALUOut. On mem_ready: MDR<=mem_rdata, go to MEMWB.
- MEMWB: rd<=MDR; retire; go to FETCH.
- MEMWR: request a write of B to ALUOut. On mem_ready: retire, go to FETCH.
- EXEC: ALUOut<=A op (B or I-immediate).
- ALUWB: rd<=ALUOut; retire; go to FETCH.
- BRANCH: if A==B then PC<=ALUOut; retire; go to FETCH.
- HALT
  - Absorbing; only reset exits it.
  - mem_req=0, halted=1.
  - The instruction that caused HALT does not retire.
- Arithmetic: all ALU results truncate to XLEN bits, wrap-around with no flags. Addresses are not checked for alignment; mem_addr passes through unmodified.

## Timing
- Reset values: PC=RESET_PC; all registers, IR, MDR, A, B, ALUOut = 0; retired=0; state=FETCH; mem_req=0; mem_we=0; halted=0.
- The first mem_req=1 appears in the first cycle after reset deasserts.
- Handshake
  - mem_req, mem_addr, mem_we and mem_wdata are Moore outputs of the state.
  - They stay stable while mem_req=1 and mem_ready=0.
  - The transfer completes at the first posedge where mem_req=1 and mem_ready=1; zero-wait is allowed.
  - mem_ready is ignored when mem_req=0.
- Cycles per instruction with zero wait states: beq 3, R-type/addi 4, sd 4, ld 5. Each wait cycle on FETCH, MEMRD or MEMWR adds one.
- retired increments on the posedge that leaves MEMWB, ALUWB, MEMWR (on accept) or BRANCH.
- PC writes happen at two points only: FETCH accept and a taken branch in BRANCH.
- Reset mid-access: mem_req drops combinationally with reset. Partial state is discarded and no register write or retire occurs.

## Test plan
- Reset: hold reset 3 cycles with RESET_PC=0x100 -> pc=0x100, retired=0, mem_req=0, halted=0. First fetch has mem_addr=0x100.
- ALU: program addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1; zero-wait memory.
  - Required: x3=2, x4=-8 (0xFFFF_FFFF_FFFF_FFF8).
  - retired=4 after exactly 16 cycles.
- Memory with waits: memory inserts 2 wait cycles per access; run sd x3,8(x0) then ld x5,8(x0).
  - Store: mem_we=1, mem_addr=8, wdata=2, all stable for 3 cycles.
  - Result: x5=2; ld takes 5+2+2 cycles.
- Branch: beq x1,x1,-8 -> PC jumps to OldPC-8. beq x1,x2,+16 -> PC=OldPC+4. Each takes 3 cycles.
- x0 and illegal opcode:
  - addi x0,x0,7 -> x0 still reads 0, retired increments.
  - Next word 0xFFFFFFFF -> halted=1 after DECODE, mem_req stays 0, retired unchanged.
- Reset during MEMRD wait: assert reset mid-wait -> mem_req=0 immediately, no register write, pc=RESET_PC.
